// File: rtl/fpga_cfg_pkg.sv
// Shared constants, select encodings and FSM states for the configuration loader.
// The stream layout offsets are also used by the address decoder (and later readback).
package fpga_cfg_pkg;

    localparam int NUM_LUT   = 11;
    localparam int NUM_SB    = 20;
    localparam int WORD_W    = 32;
    localparam int CFG_WORDS = 2 * NUM_LUT + NUM_SB + 1;

    localparam logic [5:0] LUT_TT_BASE   = 6'd0;
    localparam logic [5:0] SB_BASE       = 6'd11;
    localparam logic [5:0] LUT_MODE_BASE = 6'd31;
    localparam logic [5:0] CSUM_IDX      = 6'd42;

    typedef enum logic [1:0] {
        CFG_SEL_LUT_TT = 2'd0,
        CFG_SEL_SB     = 2'd1,
        CFG_SEL_MODE   = 2'd2,
        CFG_SEL_NONE   = 2'd3
    } cfg_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/cfg_addr_decode.sv
// Maps a stream word counter onto target class, element index and payload flag.
// Purely combinational so the readback path can reuse the same map.
module cfg_addr_decode
    import fpga_cfg_pkg::*;
(
    input  logic [5:0] cnt,
    output logic [1:0] sel,
    output logic [4:0] idx,
    output logic       payload
);

    always_comb begin
        sel     = CFG_SEL_NONE;
        idx     = '0;
        payload = 1'b0;
        if (cnt < SB_BASE) begin
            sel     = CFG_SEL_LUT_TT;
            idx     = 5'(cnt - LUT_TT_BASE);
            payload = 1'b1;
        end else if (cnt < LUT_MODE_BASE) begin
            sel     = CFG_SEL_SB;
            idx     = 5'(cnt - SB_BASE);
            payload = 1'b1;
        end else if (cnt < CSUM_IDX) begin
            sel     = CFG_SEL_MODE;
            idx     = 5'(cnt - LUT_MODE_BASE);
            payload = 1'b1;
        end
    end

endmodule

// File: rtl/fpga_config_loader.sv
// Streams LUT/switch-box/mode configuration words into the fabric and checks a
// trailing XOR checksum; the fabric stays disabled unless the load ends cleanly.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, waiting for start
// LOAD    | accepting words 0..42, issuing one write per payload word
// DONE    | checksum matched, fabric enabled, waiting for start
// ERR     | checksum mismatch, fabric disabled, waiting for start
module fpga_config_loader
    import fpga_cfg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [1:0]  wr_sel,
    output logic [4:0]  wr_idx,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        fabric_en
);

    cfg_state_e  state_q;
    cfg_state_e  state_d;
    logic [5:0]  cnt_q;
    logic [31:0] acc_q;
    logic        accept;
    logic        is_csum;
    logic        csum_ok;
    logic [1:0]  dec_sel;
    logic [4:0]  dec_idx;
    logic        dec_payload;

    cfg_addr_decode u_decode (
        .cnt     (cnt_q),
        .sel     (dec_sel),
        .idx     (dec_idx),
        .payload (dec_payload)
    );

    assign accept  = in_valid & in_ready;
    assign is_csum = (cnt_q == CSUM_IDX);
    assign csum_ok = (in_data == acc_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && is_csum) begin
                    state_d = csum_ok ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign fabric_en = (state_q == ST_DONE);

    // Counter, checksum and registered write port; reset also kills any pending strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            wr_en   <= 1'b0;
            wr_sel  <= '0;
            wr_idx  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state_q != ST_LOAD) begin
                if (start) begin
                    cnt_q <= '0;
                    acc_q <= '0;
                end
            end else if (accept) begin
                if (dec_payload) begin
                    cnt_q   <= cnt_q + 6'd1;
                    acc_q   <= acc_q ^ in_data;
                    wr_en   <= 1'b1;
                    wr_sel  <= dec_sel;
                    wr_idx  <= dec_idx;
                    wr_data <= (dec_sel == CFG_SEL_MODE) ? {31'b0, in_data[0]} : in_data;
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end

endmodule
